// File: rtl/cmpx_mult4x4.sv
// cmpx_mult4x4: sequential 4-bit complex multiplier, out = {re, im} = a * b.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   start    begin a multiplication (accepted in IDLE or DONE only)
//   a        operand A: a[7:4] real x, a[3:0] imag y (unsigned)
//   b        operand B: b[7:4] real z, b[3:0] imag w (unsigned)
//   out      {re, im}, 8-bit two's complement each
//   done     result valid, held until the next accepted start
//   outReal  re (out[15:8])
//   outImag  im (out[7:0])
//   busy     only with CMPX_MULT_BUSY_EN defined: high while multiplying
module cmpx_mult4x4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] out,
  output logic        done,
  output logic [7:0]  outReal,
  output logic [7:0]  outImag
`ifdef CMPX_MULT_BUSY_EN
  ,
  output logic        busy
`endif
);
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_e;
  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d, re_q, re_d, im_q, im_d, prod_q, prod_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  mcand, mplier;
  logic [7:0]  pp, sum;
  logic        sub, to_im, idle;
  // Partial products: MUL0 x*z, MUL1 y*w, MUL2 x*w, MUL3 y*z.
  assign mcand  = (state_q == MUL0 || state_q == MUL2) ? a_q[7:4] : a_q[3:0];
  assign mplier = (state_q == MUL0 || state_q == MUL3) ? b_q[7:4] : b_q[3:0];
  // One shift-add step per cycle, LSB-first over the multiplier bits.
  assign pp     = mplier[cnt_q[1:0]] ? ({4'd0, mcand} << cnt_q[1:0]) : 8'd0;
  assign sub    = state_q == MUL1;
  assign to_im  = state_q == MUL2 || state_q == MUL3;
  // Shared adder/subtractor: invert the product and add sub as carry-in.
  assign sum    = (to_im ? im_q : re_q) + (prod_q ^ {8{sub}}) + {7'd0, sub};
  assign idle   = state_q == IDLE || state_q == DONE;
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    re_d    = re_q;
    im_d    = im_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    if (idle) begin
      if (start) begin
        a_d     = a;
        b_d     = b;
        re_d    = 8'd0;
        im_d    = 8'd0;
        prod_d  = 8'd0;
        cnt_d   = 3'd0;
        state_d = MUL0;
      end
    end else if (cnt_q != 3'd4) begin
      prod_d = prod_q + pp;
      cnt_d  = cnt_q + 3'd1;
    end else begin
      prod_d  = 8'd0;
      cnt_d   = 3'd0;
      re_d    = to_im ? re_q : sum;
      im_d    = to_im ? sum : im_q;
      state_d = state_q == MUL3 ? DONE : state_e'(state_q + 3'd1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      re_q    <= 8'd0;
      im_q    <= 8'd0;
      prod_q  <= 8'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      re_q    <= re_d;
      im_q    <= im_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end
  assign out     = {re_q, im_q};
  assign outReal = re_q;
  assign outImag = im_q;
  assign done    = state_q == DONE;
`ifdef CMPX_MULT_BUSY_EN
  assign busy    = !idle;
`endif
endmodule

// File: tb/tb_cmpx_mult4x4.sv
// tb_cmpx_mult4x4: directed and random checks of cmpx_mult4x4 against an arithmetic model.
module tb_cmpx_mult4x4;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [7:0]  a = 8'd0, b = 8'd0, outReal, outImag;
  logic [15:0] out;
  logic        done;
  int          tests = 0, fails = 0;
`ifdef CMPX_MULT_BUSY_EN
  logic        busy;
`endif
  cmpx_mult4x4 dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .out(out), .done(done), .outReal(outReal), .outImag(outImag)
`ifdef CMPX_MULT_BUSY_EN
    , .busy(busy)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One full multiplication; mid perturbs operands/start during the run,
  // rel releases reset on the same negedge that raises start.
  task automatic run(input logic [7:0] av, input logic [7:0] bv, input bit mid, input bit rel);
    int x, y, z, w;
    logic [7:0] er, ei;
    x = int'(av[7:4]); y = int'(av[3:0]); z = int'(bv[7:4]); w = int'(bv[3:0]);
    er = 8'((x * z - y * w) & 255);
    ei = 8'((x * w + y * z) & 255);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    if (rel) rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_after_start", {15'd0, done}, 16'd0);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 5)  chk("re_after_p0", {8'd0, outReal}, {8'd0, 8'((x * z) & 255)});
      if (k == 10) chk("re_after_p1", {8'd0, outReal}, {8'd0, er});
      if (k == 15) chk("im_after_p2", {8'd0, outImag}, {8'd0, 8'((x * w) & 255)});
      if (k < 20)  chk("done_busy_phase", {15'd0, done}, 16'd0);
`ifdef CMPX_MULT_BUSY_EN
      chk("busy", {15'd0, busy}, {15'd0, k < 20});
`endif
      if (mid && k == 8) begin
        a = 8'($urandom); b = 8'($urandom); start = 1'b1;
      end
    end
    chk("done_at_E20", {15'd0, done}, 16'd1);
    chk("out", out, {er, ei});
    chk("outReal", {8'd0, outReal}, {8'd0, er});
    chk("outImag", {8'd0, outImag}, {8'd0, ei});
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = ~start; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      chk("reset_out", out, 16'd0);
      chk("reset_done", {15'd0, done}, 16'd0);
    end
    @(negedge clk); start = 1'b0; rst = 1'b1;
    run(8'h23, 8'h21, 1'b0, 1'b0);
    run(8'h22, 8'h12, 1'b0, 1'b0);
    run(8'h10, 8'h13, 1'b1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_held", {15'd0, done}, 16'd1);
      chk("out_held", out, 16'h0103);
    end
    run(8'hFF, 8'hFF, 1'b0, 1'b0);
    @(negedge clk); a = 8'h57; b = 8'h34; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1; rst = 1'b0; #1;
    chk("midrun_reset_out", out, 16'd0);
    chk("midrun_reset_done", {15'd0, done}, 16'd0);
    run(8'h76, 8'h45, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) run(8'($urandom), 8'($urandom), i[0], 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
